ram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-port `synchronous_ram` (1024 x 8, shared tristate data bus). It accepts read/write commands from two independent requesters (A and B) and drives the RAM's `cs`/`rd`/`wr`/`addr`/`data` pins with legal sequences. It owns the bidirectional data bus and returns read data per port with a valid pulse. It sits between the RAM and its two client blocks; no client touches the RAM pins directly.

---
 rtl/ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter and sequencer for a single-port synchronous RAM
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;      // 1 = port B was granted last
  logic          sel_q, sel_d;        // 1 = port B owns the current operation
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ram_cs_q, ram_cs_d;
  logic          ram_rd_q, ram_rd_d;
  logic          ram_wr_q, ram_wr_d;
  logic          drive_q, drive_d;
  logic          busy_q, busy_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          pick_b;
  logic          sel_we;

  // Next-state and next-output logic; every output is computed one cycle ahead and registered
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    ram_cs_d   = ram_cs_q;
    ram_rd_d   = ram_rd_q;
    ram_wr_d   = ram_wr_q;
    drive_d    = 1'b0;
    busy_d     = busy_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    // B wins when it is the only requester, or on a tie when A was served last
    pick_b     = b_req && (!a_req || !last_q);
    sel_we     = pick_b ? b_we : a_we;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          sel_d      = pick_b;
          last_d     = pick_b;
          ram_addr_d = pick_b ? b_addr : a_addr;
          wdata_d    = pick_b ? b_wdata : a_wdata;
          ram_cs_d   = 1'b1;
          busy_d     = 1'b1;
          a_gnt_d    = !pick_b;
          b_gnt_d    = pick_b;
          if (sel_we) begin
            state_d  = WR;
            ram_wr_d = 1'b1;
            drive_d  = 1'b1;
          end else begin
            state_d  = RD1;
            ram_rd_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d  = IDLE;
        ram_cs_d = 1'b0;
        ram_wr_d = 1'b0;
        busy_d   = 1'b0;
      end
      RD1: begin
        // strobes held so the RAM drives its output register during RD2
        state_d = RD2;
      end
      RD2: begin
        state_d  = IDLE;
        ram_cs_d = 1'b0;
        ram_rd_d = 1'b0;
        busy_d   = 1'b0;
        if (sel_q) begin
          b_rdata_d  = ram_data;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = ram_data;
          a_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight read and its data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      ram_cs_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      ram_cs_q   <= ram_cs_d;
      ram_rd_q   <= ram_rd_d;
      ram_wr_q   <= ram_wr_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign ram_data = drive_q ? wdata_q : {DW{1'bz}};
  assign ram_cs   = ram_cs_q;
  assign ram_rd   = ram_rd_q;
  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign busy     = busy_q;
  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed-vector bench for ram_arbiter with a behavioural synchronous RAM
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       busy, ram_cs, ram_rd, ram_wr;
  logic [9:0] ram_addr;
  wire  [7:0] ram_data;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  ram_arbiter #(.AW(10), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .busy(busy), .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // behavioural 1024x8 RAM: output register loads while cs&rd, drives the bus one cycle later
  logic [7:0] mem [0:1023];
  logic [7:0] ram_q;
  logic       ram_oe = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;
    if (ram_cs && ram_rd) ram_q <= mem[ram_addr];
    ram_oe <= ram_cs && ram_rd && !ram_wr;
  end
  assign ram_data = (ram_oe && ram_cs && ram_rd) ? ram_q : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // invariants sampled every cycle
  always @(negedge clk) begin
    if (ram_cs) check("rd_wr_excl", {31'd0, ram_rd & ram_wr}, 0);
    if (a_gnt || b_gnt) check("gnt_onehot", {31'd0, a_gnt & b_gnt}, 0);
    check("cs_tracks_busy", {31'd0, ram_cs}, {31'd0, busy});
  end

  task automatic do_reset();
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input bit port, input bit we, input logic [9:0] addr, input logic [7:0] wd);
    if (port) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
  endtask

  task automatic wait_gnt(input bit port);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? b_gnt : a_gnt) got = 1;
    end
    check("gnt_seen", {31'd0, got}, 1);
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic do_write(input bit port, input logic [9:0] addr, input logic [7:0] wd);
    issue(port, 1'b1, addr, wd);
    wait_gnt(port);
    @(negedge clk);
  endtask

  task automatic do_read(input bit port, input logic [9:0] addr, output logic [7:0] rd);
    bit got = 0;
    issue(port, 1'b0, addr, 8'h00);
    wait_gnt(port);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (port ? b_rvalid : a_rvalid) got = 1;
    end
    check("rvalid_seen", {31'd0, got}, 1);
    rd = port ? b_rdata : a_rdata;
  endtask

  task automatic wait_any(output logic [1:0] who);
    who = 2'b00;
    for (int i = 0; i < 10 && who == 2'b00; i++) begin
      @(negedge clk);
      who = {a_gnt, b_gnt};
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] who;
    int prev, ngnt, wcnt;
    bit got;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h3FF] = 8'h5C;
    mem[10'h000] = 8'h77;
    a_we = 0; a_addr = 0; a_wdata = 0; b_we = 0; b_addr = 0; b_wdata = 0;

    // reset values
    do_reset();
    check("rst_ctl", {24'd0, ram_cs, ram_rd, ram_wr, busy, a_gnt, b_gnt, a_rvalid, b_rvalid}, 0);
    check("rst_addr", {22'd0, ram_addr}, 0);
    check("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);

    // port A write then read, exact cycle timing
    @(negedge clk);
    issue(1'b0, 1'b1, 10'h003, 8'hA5);
    @(negedge clk);
    check("wr_gnt", {30'd0, a_gnt, b_gnt}, 2'b10);
    check("wr_strobes", {29'd0, ram_cs, ram_wr, ram_rd}, 3'b110);
    check("wr_addr", {22'd0, ram_addr}, 10'h003);
    a_req = 1'b0;
    @(negedge clk);
    check("wr_done", {30'd0, ram_wr, busy}, 0);
    check("wr_mem", {24'd0, mem[10'h003]}, 8'hA5);
    issue(1'b0, 1'b0, 10'h003, 8'h00);
    @(negedge clk);
    check("rd1", {29'd0, a_gnt, ram_rd, ram_wr}, 3'b110);
    a_req = 1'b0;
    @(negedge clk);
    check("rd2", {29'd0, a_gnt, ram_rd, a_rvalid}, 3'b010);
    @(negedge clk);
    check("rd_valid", {31'd0, a_rvalid}, 1);
    check("rd_data", {24'd0, a_rdata}, 8'hA5);
    check("rd_b_untouched", {24'd0, b_rdata}, 0);
    check("rd_idle", {31'd0, busy}, 0);
    @(negedge clk);
    check("rvalid_pulse", {31'd0, a_rvalid}, 0);
    check("rdata_hold", {24'd0, a_rdata}, 8'hA5);

    // simultaneous requests after reset: A first, B at the next IDLE
    do_reset();
    issue(1'b0, 1'b1, 10'h010, 8'h11);
    issue(1'b1, 1'b0, 10'h3FF, 8'h00);
    @(negedge clk);
    check("tie_first", {30'd0, a_gnt, b_gnt}, 2'b10);
    a_req = 1'b0;
    @(negedge clk);
    check("tie_gap", {31'd0, b_gnt}, 0);
    @(negedge clk);
    check("tie_second", {30'd0, a_gnt, b_gnt}, 2'b01);
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    check("tie_b_rvalid", {31'd0, b_rvalid}, 1);
    check("tie_b_rdata", {24'd0, b_rdata}, 8'h5C);
    check("tie_a_mem", {24'd0, mem[10'h010]}, 8'h11);

    // four contended writes alternate A, B, A, B
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      issue(1'b0, 1'b1, 10'h020 + 10'(r), 8'h20);
      issue(1'b1, 1'b1, 10'h030 + 10'(r), 8'h30);
      wait_any(who);
      check("rr_a", {30'd0, who}, 2'b10);
      a_req = 1'b0;
      wait_any(who);
      check("rr_b", {30'd0, who}, 2'b01);
      b_req = 1'b0;
      @(negedge clk);
    end

    // boundary addresses
    do_write(1'b0, 10'h3FF, 8'hFF);
    do_write(1'b1, 10'h000, 8'h00);
    do_read(1'b0, 10'h000, rd);
    check("bnd_lo", {24'd0, rd}, 8'h00);
    do_read(1'b1, 10'h3FF, rd);
    check("bnd_hi", {24'd0, rd}, 8'hFF);

    // reset during RD2 of a B read
    issue(1'b1, 1'b0, 10'h010, 8'h00);
    @(negedge clk);
    check("rst_rd_gnt", {31'd0, b_gnt}, 1);
    b_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rd_state", {29'd0, b_rvalid, busy, ram_cs}, 0);
    check("rst_rd_rdata", {24'd0, b_rdata}, 0);
    @(negedge clk);
    check("rst_rd_no_late", {31'd0, b_rvalid}, 0);

    // reset at the end of a WR cycle still commits the write
    issue(1'b0, 1'b1, 10'h155, 8'h3C);
    @(negedge clk);
    check("rst_wr_gnt", {31'd0, a_gnt}, 1);
    a_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wr_idle", {31'd0, busy}, 0);
    do_read(1'b0, 10'h155, rd);
    check("rst_wr_kept", {24'd0, rd}, 8'h3C);

    // B streams reads; grants every 3 cycles, then A gets in within one operation
    b_we = 1'b0; b_addr = 10'h010; b_req = 1'b1;
    prev = -1; ngnt = 0;
    for (int i = 0; i < 40 && ngnt < 4; i++) begin
      @(negedge clk);
      if (b_gnt) begin
        if (prev >= 0) check("stream_gap", cyc - prev, 3);
        prev = cyc;
        ngnt++;
      end
    end
    check("stream_gnts", ngnt, 4);
    issue(1'b0, 1'b0, 10'h003, 8'h00);
    wcnt = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      wcnt++;
      if (a_gnt) got = 1;
    end
    check("a_gnt_wait", wcnt, 3);
    a_req = 1'b0; b_req = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_rvalid) got = 1;
    end
    check("a_stream_rvalid", {31'd0, got}, 1);
    check("a_stream_rdata", {24'd0, a_rdata}, 8'hA5);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
